// File: rtl/inference_scheduler.sv
// -----------------------------------------------------------------------------
// inference_scheduler
//
// Sequences a single-layer binarised-image classifier. Each of the NUM_CLASSES
// output neurons is processed as follows:
//    - A dot product of the NUM_PIX image bits with that neuron's signed
//      weights is accumulated.
//    - The result is compared against the running best, and the highest
//      score wins.
//    - On a tie, the lowest neuron index is kept.
// The result is published with a one-cycle done pulse.
//
// Ports
//    clk          clock
//    rst          asynchronous active-high reset
//    start        request inference on the loaded image (sampled in IDLE only)
//    pix_addr     pixel index presented to the image store
//    pix_bit      image bit at pix_addr, combinational
//    w_addr       weight ROM address = neuron_idx*NUM_PIX + pix_addr
//    w_data       signed weight, valid one cycle after w_addr
//    busy         high whenever the scheduler is not idle
//    done         one-cycle pulse, classification valid
//    class_bcd    winning class index (held until next done or reset)
//    class_score  winning neuron's signed score (held until next done or reset)
// -----------------------------------------------------------------------------
module inference_scheduler #(
   parameter int NUM_PIX     = 196,
   parameter int NUM_CLASSES = 10,
   parameter int W_WIDTH     = 8,
   parameter int ACC_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [7:0]           pix_addr,
   input  logic                 pix_bit,
   output logic [10:0]          w_addr,
   input  logic [W_WIDTH-1:0]   w_data,
   output logic                 busy,
   output logic                 done,
   output logic [3:0]           class_bcd,
   output logic [ACC_WIDTH-1:0] class_score
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_MAC     = 3'd1;
   localparam logic [2:0] S_DRAIN   = 3'd2;
   localparam logic [2:0] S_COMPARE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [7:0] LAST_PIX    = 8'(NUM_PIX - 1);
   localparam logic [3:0] LAST_NEURON = 4'(NUM_CLASSES - 1);
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic [2:0]                  state;
   logic [2:0]                  next_state;
   logic [3:0]                  neuron_idx;
   logic [3:0]                  best_idx;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] best_score;
   logic signed [ACC_WIDTH-1:0] w_ext;
   logic                        pix_bit_d1;   // pixel bit delayed to line up with w_data
   logic                        pair_valid;   // pix_bit_d1/w_data form a real product
   logic                        better;

   assign w_ext  = {{(ACC_WIDTH-W_WIDTH){w_data[W_WIDTH-1]}}, w_data};
   assign better = (acc > best_score);

   // Next-state decode of the scheduler FSM
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               next_state = S_MAC;
            end else begin
               next_state = S_IDLE;
            end
         end
         S_MAC: begin
            if (pix_addr == LAST_PIX) begin
               next_state = S_DRAIN;
            end else begin
               next_state = S_MAC;
            end
         end
         S_DRAIN: begin
            next_state = S_COMPARE;
         end
         S_COMPARE: begin
            if (neuron_idx == LAST_NEURON) begin
               next_state = S_DONE;
            end else begin
               next_state = S_MAC;
            end
         end
         S_DONE: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // State, address generation, accumulation and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         pix_addr    <= 8'd0;
         w_addr      <= 11'd0;
         neuron_idx  <= 4'd0;
         best_idx    <= 4'd0;
         acc         <= '0;
         best_score  <= '0;
         pix_bit_d1  <= 1'b0;
         pair_valid  <= 1'b0;
         class_bcd   <= 4'd0;
         class_score <= '0;
      end else begin
         state      <= next_state;
         busy       <= (next_state != S_IDLE);
         done       <= (next_state == S_DONE);
         pix_bit_d1 <= pix_bit;
         // A product is valid in the cycle after an address was issued in MAC;
         // entry into MAC (from IDLE or COMPARE) therefore never accumulates.
         pair_valid <= (state == S_MAC);
         case (state)
            S_IDLE: begin
               if (start) begin
                  neuron_idx <= 4'd0;
                  pix_addr   <= 8'd0;
                  w_addr     <= 11'd0;
                  acc        <= '0;
                  best_score <= ACC_MIN;
                  best_idx   <= 4'd0;
               end
            end
            S_MAC: begin
               if (pair_valid && pix_bit_d1) begin
                  acc <= acc + w_ext;
               end
               // The address holds on the final pixel; DRAIN issues nothing new.
               if (pix_addr != LAST_PIX) begin
                  pix_addr <= pix_addr + 8'd1;
                  w_addr   <= w_addr + 11'd1;
               end
            end
            S_DRAIN: begin
               if (pair_valid && pix_bit_d1) begin
                  acc <= acc + w_ext;
               end
            end
            S_COMPARE: begin
               // Strict compare: a tie keeps the earlier (lower) index.
               if (better) begin
                  best_score <= acc;
                  best_idx   <= neuron_idx;
               end
               if (neuron_idx == LAST_NEURON) begin
                  class_bcd   <= better ? neuron_idx : best_idx;
                  class_score <= better ? acc : best_score;
               end else begin
                  neuron_idx <= neuron_idx + 4'd1;
                  acc        <= '0;
                  pix_addr   <= 8'd0;
                  // Weights are laid out neuron-major, so the next neuron's
                  // first weight directly follows the last one just read.
                  w_addr     <= w_addr + 11'd1;
               end
            end
            S_DONE: begin
               acc <= acc;
            end
            default: begin
               acc <= acc;
            end
         endcase
      end
   end

endmodule
